// File: rtl/demux_pkg.sv
// Shared definitions for the buffered 4-way bus demultiplexer.
package demux_pkg;

   // Destination channel carried on the control lines.
   typedef enum logic [1:0] {
      FIRST  = 2'd0,
      SECOND = 2'd1,
      THIRD  = 2'd2,
      FOURTH = 2'd3
   } channel_t;

   localparam int NUM_CHANNELS = 4;

endpackage

// File: rtl/demux_channel_fifo.sv
// One per-channel synchronous FIFO. The head word is held in a register so
// the channel output stays at the last delivered word once the FIFO drains.
//
// Handshake: a word is written when push_i is high (the caller only raises
// it when full_o is low); the head is consumed on an edge where valid_o and
// pop_i are both high. Neither side has a combinational path to the other.
module demux_channel_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             n_reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             valid_o,
   output logic [WIDTH-1:0] head_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic             valid_q;
   logic             pop;

   assign pop     = pop_i && valid_q;
   assign full_o  = (count_q == CW'(DEPTH));
   assign valid_o = valid_q;
   assign head_o  = head_q;

   // Next pointers, occupancy and the word that will sit at the head after the edge.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      head_d   = head_q;
      if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)    rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push_i) - CW'(pop);
      // The new head may be the word being written this very edge.
      if (count_d != '0) begin
         if (push_i && (wr_ptr_q == rd_ptr_d)) head_d = push_data_i;
         else                                  head_d = mem_q[rd_ptr_d];
      end
   end

   // State registers; reset flushes everything including the held head word.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         if (push_i) mem_q[wr_ptr_q] <= push_data_i;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
         valid_q  <= (count_d != '0);
      end
   end

endmodule

// File: rtl/demux_4_buffered.sv
// Receive side of the shared 4:1 bus: routes each enabled bus word into
// one of four channel FIFOs chosen by control, drained by valid/ready.
//
// Handshake: the bus side transfers on an edge where n_in_enable is low and
// in_ready is high; in_ready depends only on control and registered state.
// Channel i transfers on an edge where out_valid[i] and out_ready[i] are high.
module demux_4_buffered
   import demux_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             n_reset,
   input  logic [WIDTH-1:0] bus_data,
   input  logic [1:0]       control,
   input  logic             n_in_enable,
   output logic             in_ready,
   output logic [WIDTH-1:0] first_channel,
   output logic [WIDTH-1:0] second_channel,
   output logic [WIDTH-1:0] third_channel,
   output logic [WIDTH-1:0] fourth_channel,
   output logic [3:0]       out_valid,
   input  logic [3:0]       out_ready
);

   channel_t         sel;
   logic             bus_push;
   logic [3:0]       push_w;
   logic [3:0]       full_w;
   logic [WIDTH-1:0] head_w [NUM_CHANNELS];

   assign sel = channel_t'(control);

   // Back-pressure is the full flag of the addressed channel only.
   always_comb begin
      in_ready = ~full_w[sel];
   end

   // A disabled bus gates the push first, so floating data/select never reach state.
   always_comb begin
      bus_push = ~n_in_enable & in_ready;
      push_w   = '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         push_w[i] = bus_push && (control == 2'(i));
      end
   end

   for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
      demux_channel_fifo #(
         .WIDTH (WIDTH),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk         (clk),
         .n_reset     (n_reset),
         .push_i      (push_w[g]),
         .push_data_i (bus_data),
         .pop_i       (out_ready[g]),
         .full_o      (full_w[g]),
         .valid_o     (out_valid[g]),
         .head_o      (head_w[g])
      );
   end

   assign first_channel  = head_w[0];
   assign second_channel = head_w[1];
   assign third_channel  = head_w[2];
   assign fourth_channel = head_w[3];

endmodule

// File: tb/tb_demux_4_buffered.sv
// Directed bench for demux_4_buffered with a queue-based reference model.
module tb_demux_4_buffered;

   localparam int WIDTH = 32;
   localparam int DEPTH = 2;

   logic             clk;
   logic             n_reset;
   logic [WIDTH-1:0] bus_data;
   logic [1:0]       control;
   logic             n_in_enable;
   logic             in_ready;
   logic [WIDTH-1:0] first_channel, second_channel, third_channel, fourth_channel;
   logic [3:0]       out_valid;
   logic [3:0]       out_ready;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 0;

   // Reference model: one word queue per channel plus the last head shown.
   logic [WIDTH-1:0] exp_q [4][$];
   logic [WIDTH-1:0] last_head [4];

   demux_4_buffered #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .n_reset        (n_reset),
      .bus_data       (bus_data),
      .control        (control),
      .n_in_enable    (n_in_enable),
      .in_ready       (in_ready),
      .first_channel  (first_channel),
      .second_channel (second_channel),
      .third_channel  (third_channel),
      .fourth_channel (fourth_channel),
      .out_valid      (out_valid),
      .out_ready      (out_ready)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [WIDTH-1:0] act,
                        input logic [WIDTH-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model update: FIFO semantics straight from the push/pop rules.
   int  m_c;
   bit  m_push;
   bit  m_pop [4];
   always @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         for (int i = 0; i < 4; i++) begin
            exp_q[i].delete();
            last_head[i] <= '0;
         end
      end else begin
         m_c    = int'(control);
         m_push = !n_in_enable && (exp_q[m_c].size() < DEPTH);
         for (int i = 0; i < 4; i++) m_pop[i] = (exp_q[i].size() > 0) && out_ready[i];
         for (int i = 0; i < 4; i++) if (m_pop[i]) void'(exp_q[i].pop_front());
         if (m_push) exp_q[m_c].push_back(bus_data);
         for (int i = 0; i < 4; i++) if (exp_q[i].size() > 0) last_head[i] <= exp_q[i][0];
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         logic [3:0] ev;
         for (int i = 0; i < 4; i++) ev[i] = (exp_q[i].size() != 0);
         check("cyc out_valid", WIDTH'(out_valid), WIDTH'(ev));
         check("cyc first_channel",  first_channel,  last_head[0]);
         check("cyc second_channel", second_channel, last_head[1]);
         check("cyc third_channel",  third_channel,  last_head[2]);
         check("cyc fourth_channel", fourth_channel, last_head[3]);
         check("cyc in_ready", WIDTH'(in_ready),
               WIDTH'(exp_q[int'(control)].size() < DEPTH));
      end
   end

   // Driver: inputs change 2 time units after a rising edge, used by the next one.
   task automatic drive(input logic en_n, input logic [1:0] ctl,
                        input logic [WIDTH-1:0] data, input logic [3:0] rdy);
      @(posedge clk);
      #2;
      n_in_enable = en_n;
      control     = ctl;
      bus_data    = data;
      out_ready   = rdy;
   endtask

   task automatic idle();
      drive(1'b1, 2'd0, '0, 4'b0000);
   endtask

   initial begin
      logic [WIDTH-1:0] xw;
      xw          = 'x;
      n_reset     = 1'b0;
      n_in_enable = 1'b1;
      control     = 2'd0;
      bus_data    = '0;
      out_ready   = 4'b0000;

      // Reset
      repeat (3) @(posedge clk);
      #2;
      n_reset = 1'b1;
      chk_en  = 1;
      #1;
      check("reset out_valid", WIDTH'(out_valid), 0);
      check("reset in_ready", WIDTH'(in_ready), 1);
      check("reset first_channel", first_channel, 0);
      check("reset second_channel", second_channel, 0);
      check("reset third_channel", third_channel, 0);
      check("reset fourth_channel", fourth_channel, 0);

      // Basic route to channel 2
      drive(1'b0, 2'd2, 32'hA5A5_0001, 4'b0000);
      idle();
      check("route out_valid", WIDTH'(out_valid), WIDTH'(4'b0100));
      check("route third_channel", third_channel, 32'hA5A5_0001);

      // Full / stall on channel 0
      drive(1'b0, 2'd0, 32'h11, 4'b0000);
      drive(1'b0, 2'd0, 32'h22, 4'b0000);
      drive(1'b0, 2'd0, 32'h33, 4'b0000);
      #1;
      check("stall in_ready", WIDTH'(in_ready), 0);
      check("stall first_channel", first_channel, 32'h11);
      drive(1'b0, 2'd0, 32'h33, 4'b0001);
      drive(1'b0, 2'd0, 32'h33, 4'b0000);
      #1;
      check("after pop first_channel", first_channel, 32'h22);
      check("after pop in_ready", WIDTH'(in_ready), 1);
      idle();
      check("33 accepted out_valid", WIDTH'(out_valid), WIDTH'(4'b0101));
      check("33 accepted head", first_channel, 32'h22);
      drive(1'b1, 2'd0, '0, 4'b0001);
      idle();
      check("head 33", first_channel, 32'h33);

      // Disabled bus with floating data
      for (int k = 0; k < 5; k++) drive(1'b1, 2'd1, xw, 4'b0000);
      idle();
      check("disabled out_valid", WIDTH'(out_valid), WIDTH'(4'b0101));
      check("disabled second_channel", second_channel, 0);

      // Simultaneous push and pop on channel 3
      drive(1'b0, 2'd3, 32'h1234, 4'b0000);
      drive(1'b0, 2'd3, 32'hBEEF, 4'b1000);
      idle();
      check("pushpop out_valid", WIDTH'(out_valid), WIDTH'(4'b1101));
      check("pushpop fourth_channel", fourth_channel, 32'hBEEF);

      // Mid-operation reset
      drive(1'b0, 2'd0, 32'hF0, 4'b0000);
      drive(1'b0, 2'd1, 32'hF1, 4'b0000);
      drive(1'b0, 2'd2, 32'hF2, 4'b0000);
      drive(1'b0, 2'd3, 32'hF3, 4'b0000);
      drive(1'b1, 2'd1, '0, 4'b0000);
      check("filled out_valid", WIDTH'(out_valid), WIDTH'(4'b1111));
      @(posedge clk);
      #2;
      n_reset = 1'b0;
      #1;
      check("async out_valid", WIDTH'(out_valid), 0);
      check("async in_ready", WIDTH'(in_ready), 1);
      check("async first_channel", first_channel, 0);
      check("async fourth_channel", fourth_channel, 0);
      #1;
      n_reset = 1'b1;
      drive(1'b0, 2'd1, 32'hCAFE, 4'b0000);
      idle();
      check("post-reset out_valid", WIDTH'(out_valid), WIDTH'(4'b0010));
      check("post-reset second_channel", second_channel, 32'hCAFE);

      // Rotating pushes with varied consumer readiness to wrap pointers
      for (int k = 0; k < 40; k++) begin
         drive(1'b0, 2'(k % 4), 32'h1000 + k * 32'h0101_0101, 4'((k * 5 + 3) % 16));
      end
      for (int k = 0; k < 3; k++) drive(1'b1, 2'd0, '0, 4'hF);
      idle();
      check("drained out_valid", WIDTH'(out_valid), 0);

      repeat (2) @(posedge clk);
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/demux_4_buffered.md
Name: demux_4_buffered

Overview:
- Receive side of the shared 4:1 tri-state mux bus.
- Samples a WIDTH-bit bus word whenever the bus driver is enabled (active-low enable, same as the mux output enable). Routes the word, by a 2-bit channel select, into one of four per-channel FIFOs.
- Downstream consumers drain the FIFOs with valid/ready handshakes.
- Sits directly behind the mux_4 bus, one clock domain; back-pressure is returned to the bus controller via in_ready.

Parameters:
- WIDTH, 32, data width of bus and all channels.
- DEPTH, 2, entries per channel FIFO; power of two, >= 2.

Ports:
- clk  input  1  rising-edge clock.
- n_reset  input  1  asynchronous active-low reset.
- bus_data  input  WIDTH  shared bus word; may float/X while n_in_enable = 1.
- control  input  2  destination channel: 0 first, 1 second, 2 third, 3 fourth.
- n_in_enable  input  1  active-low: bus is driven and carries a word this cycle.
- in_ready  output  1  selected channel can accept a word this cycle.
- first_channel, second_channel, third_channel, fourth_channel  output  WIDTH each  FIFO head word per channel.
- out_valid  output  4  bit i = channel i head valid (FIFO non-empty).
- out_ready  input  4  bit i = consumer i accepts head this cycle.

Behaviour:
- Reset (async assert, sync release): all FIFOs empty; pointers and counts = 0; out_valid = 0; all channel data outputs = 0; in_ready = 1.
- Push condition: ~n_in_enable && in_ready, sampled on the rising edge. bus_data is written to FIFO[control].
- When n_in_enable = 1: bus_data and control are ignored entirely; X/Z must not propagate into state.
- in_ready = ~full[control]. Purely combinational from control and registered state. No dependence on out_ready, so no comb path from consumers to bus.
- Stall: if the selected FIFO is full, in_ready = 0 and the bus controller must hold the word. Nothing is dropped or overwritten.
- Pop condition, per channel i: out_valid[i] && out_ready[i]. The head advances on the edge.
- out_valid[i] = ~empty[i], registered.
- The channel output is the head entry, read from storage at the read pointer, and is stable while valid and not popped.
- When a channel is empty its data output holds its last value (0 after reset). Consumers must qualify with out_valid.
- Latency: word pushed at edge N is visible on its channel output with out_valid = 1 after edge N (first cycle after push). No same-cycle bypass.
- Simultaneous push and pop on the same non-full channel: count unchanged, both pointers advance, order preserved.
- Push to a full channel cannot occur (in_ready = 0), even if that channel pops in the same cycle. The word is accepted next cycle.
- Pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH. Count is log2(DEPTH)+1 bits, range 0..DEPTH.
- Per-channel ordering is strict FIFO. No ordering guarantee exists across channels.
- Channels are fully independent: pops on any subset of channels in the same cycle are legal.
- Reset asserted mid-operation: immediate flush of all FIFOs regardless of pending handshakes. Outputs go to their reset values asynchronously.

Decomposition:
- Shared package demux_pkg:
  - channel select typedef channel_t (2-bit enum: FIRST, SECOND, THIRD, FOURTH);
  - constant NUM_CHANNELS = 4.
- Sub-module demux_channel_fifo #(WIDTH, DEPTH):
  - one synchronous FIFO with push/pop/full/empty/head;
  - instantiated four times via generate loop.
- The top level holds only the select decode and in_ready mux.

Test Plan:
- Reset: hold n_reset = 0, then release. Required: out_valid = 4'b0000, all channel outputs = 0, in_ready = 1.
- Basic route: bus_data = 32'hA5A5_0001, control = 2, n_in_enable = 0 for one cycle, out_ready = 0. Required: next cycle out_valid = 4'b0100, third_channel = 32'hA5A5_0001.
- Full/stall: push 32'h11 then 32'h22 to channel 0 with out_ready = 0; hold a third word 32'h33. Required: in_ready = 0. Raise out_ready[0] for one cycle: first_channel shows 11, then 22; 33 is accepted the cycle after in_ready returns to 1.
- Disabled bus: n_in_enable = 1, bus_data = 'z/X, control = 1 for 5 cycles. Required: out_valid unchanged, no X on any channel output.
- Simultaneous push/pop: channel 3 holds one word and out_ready[3] = 1 while a new word 32'hBEEF is pushed to channel 3. Required: out_valid[3] stays 1, fourth_channel = 32'hBEEF next cycle, no loss.
- Mid-op reset: fill all four channels, pulse n_reset low mid-cycle. Required: out_valid = 0 immediately (async), in_ready = 1; a subsequent push to channel 1 works normally.
